// File: rtl/isp_pkg.sv
// isp_pkg: shared image geometry defaults,
// pixel type and window-generator FSM states.
package isp_pkg;

  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int DEF_PIX_W = 16;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EOL,
    FLUSH
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of storage,
// single write port, single registered read port.
module line_buffer
  import isp_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_window_3x3.sv
// pixel_window_3x3: 3x3 neighbourhood generator.
// Define WINDOW_BORDER_REPLICATE_EN to replicate edge pixels instead of zero padding.
module pixel_window_3x3
  import isp_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_in,
  input  logic [16:0]        wAddr_in,
  input  logic [PIX_W-1:0]   wData_in,
  output logic               o_valid,
  output logic [16:0]        o_wAddr,
  output logic [9*PIX_W-1:0] o_win,
  output logic               o_busy
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [FW-1:0] F_PRE  = FW'(IMG_W - 1);
  localparam logic [FW-1:0] F_LAST = FW'(IMG_W);
  localparam logic [FW-1:0] F_END  = FW'(IMG_W + 1);

`ifdef WINDOW_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  // column of three pixels, index 0 = top
  typedef logic [2:0][PIX_W-1:0] col_t;

  state_t state, nstate;

  logic [XW-1:0] x_cnt, px, cx, rd_addr;
  logic [YW-1:0] y_cnt, py, cy, cy_q;
  logic [16:0]   p_cnt, pa, addr_c;
  logic [FW-1:0] fcnt;
  logic          sel, last_row;
  logic          sync, px_we, x_end, y_end;
  logic          shift, emit;
  logic [PIX_W-1:0] rd_a, rd_b, row_m1, row_m2;
  col_t col_l, col_m, ncol, rgt;
  col_t cols [3];
  logic [9*PIX_W-1:0] win_c;

  assign sync  = we_in && (wAddr_in == '0);
  assign px_we = sync || (we_in && state == RUN);
  assign px    = sync ? '0 : x_cnt;
  assign py    = sync ? '0 : y_cnt;
  assign pa    = sync ? '0 : p_cnt;
  assign x_end = (px == X_LAST);
  assign y_end = (py == Y_LAST);

  // sel=0: buffer a holds row y-1, b holds y-2
  assign row_m1 = sel ? rd_b : rd_a;
  assign row_m2 = sel ? rd_a : rd_b;
  assign ncol[0] = row_m2;
  assign ncol[1] = row_m1;
  assign ncol[2] = px_we ? wData_in : '0;

  // flush prefetches one column ahead of emission
  assign rd_addr = (state != FLUSH) ? x_cnt :
                   (fcnt < F_PRE) ? XW'(fcnt + FW'(1)) :
                   '0;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_a (
    .clk   (clk),
    .we    (px_we && sel),
    .waddr (px),
    .wdata (wData_in),
    .raddr (rd_addr),
    .rdata (rd_a)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_b (
    .clk   (clk),
    .we    (px_we && !sel),
    .waddr (px),
    .wdata (wData_in),
    .raddr (rd_addr),
    .rdata (rd_b)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // next-state decode
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (sync) nstate = RUN;
      RUN:   if (px_we && x_end && py != '0)
               nstate = EOL;
      EOL:   nstate = last_row ? FLUSH : RUN;
      FLUSH: if (sync) nstate = RUN;
             else if (fcnt == F_END) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // per-state emission controls and busy flag
  always_comb begin
    shift  = 1'b0;
    emit   = 1'b0;
    cx     = '0;
    cy     = '0;
    addr_c = o_wAddr + 17'd1;
    rgt    = ncol;
    o_busy = (state == FLUSH);
    if (px_we) begin
      shift  = 1'b1;
      emit   = (px != '0) && (py != '0);
      cx     = px - XW'(1);
      cy     = py - YW'(1);
      addr_c = pa - 17'(IMG_W + 1);
    end else if (state == EOL) begin
      emit = 1'b1;
      cx   = X_LAST;
      cy   = cy_q;
    end else if (state == FLUSH) begin
      shift = 1'b1;
      emit  = (fcnt != '0) && (fcnt <= F_LAST);
      cx    = XW'(fcnt - FW'(1));
      cy    = Y_LAST;
    end
  end

  // border padding, vertical first so corners follow the edge
  always_comb begin
    cols[0] = col_l;
    cols[1] = col_m;
    cols[2] = rgt;
    for (int c = 0; c < 3; c++) begin
      if (cy == '0)
        cols[c][0] = REPL ? cols[c][1] : '0;
      if (cy == Y_LAST)
        cols[c][2] = REPL ? cols[c][1] : '0;
    end
    if (cx == '0)
      cols[0] = REPL ? cols[1] : '0;
    if (cx == X_LAST)
      cols[2] = REPL ? cols[1] : '0;
    win_c = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_c[(r*3+c)*PIX_W +: PIX_W] = cols[c][r];
  end

  // counters, column history and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      p_cnt    <= '0;
      sel      <= 1'b0;
      last_row <= 1'b0;
      fcnt     <= '0;
      cy_q     <= '0;
      col_l    <= '0;
      col_m    <= '0;
      o_valid  <= 1'b0;
      o_wAddr  <= '0;
      o_win    <= '0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_wAddr <= addr_c;
        o_win   <= win_c;
        cy_q    <= cy;
      end
      if (shift) begin
        col_l <= col_m;
        col_m <= ncol;
      end
      if (px_we) begin
        x_cnt <= x_end ? '0 : px + XW'(1);
        if (x_end)
          y_cnt <= y_end ? '0 : py + YW'(1);
        else
          y_cnt <= py;
        p_cnt <= (x_end && y_end) ? '0 : pa + 17'd1;
        if (x_end) begin
          sel      <= ~sel;
          last_row <= y_end;
        end
      end
      if (state == FLUSH && !sync)
        fcnt <= fcnt + FW'(1);
      else
        fcnt <= '0;
    end
  end

endmodule

// File: tb/tb_pixel_window_3x3.sv
// tb_pixel_window_3x3: directed bench, ramp frames
// at full line width with a short frame height.
module tb_pixel_window_3x3;

  localparam int W  = 320;
  localparam int H  = 12;
  localparam int PW = 16;

`ifdef WINDOW_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic we_in;
  logic [16:0] wAddr_in;
  logic [15:0] wData_in;
  logic o_valid;
  logic [16:0] o_wAddr;
  logic [9*PW-1:0] o_win;
  logic o_busy;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  int last_addr = 0;

  logic v1, v2;
  logic [16:0] a1, a2;
  logic [143:0] w1, w2;

  always #5 clk = ~clk;

  pixel_window_3x3 #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .we_in    (we_in),
    .wAddr_in (wAddr_in),
    .wData_in (wData_in),
    .o_valid  (o_valid),
    .o_wAddr  (o_wAddr),
    .o_win    (o_win),
    .o_busy   (o_busy)
  );

  task automatic check(input string tag,
                       input logic [143:0] obs,
                       input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] exp_win(
      input int cx, input int cy);
    logic [143:0] w;
    logic [15:0] v;
    int xx, yy;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        xx = cx + c - 1;
        yy = cy + r - 1;
        if (REPL) begin
          if (xx < 0) xx = 0;
          if (xx > W-1) xx = W-1;
          if (yy < 0) yy = 0;
          if (yy > H-1) yy = H-1;
          v = 16'(yy*W + xx);
        end else if (xx < 0 || xx >= W ||
                     yy < 0 || yy >= H) begin
          v = '0;
        end else begin
          v = 16'(yy*W + xx);
        end
        w[(r*3+c)*16 +: 16] = v;
      end
    return w;
  endfunction

  task automatic spot(input int x, input int y);
    if (armed && x == 5 && y == 3) begin
      check("ramp_valid", v1, 1);
      check("ramp_addr", a1, 644);
      check("ramp_centre", w1[4*PW +: PW], 644);
      check("ramp_topleft", w1[0 +: PW], 323);
    end
    if (armed && x == 1 && y == 1) begin
      check("corner_addr", a1, 0);
`ifdef WINDOW_BORDER_REPLICATE_EN
      check("corner_win", w1,
            {16'd321, 16'd320, 16'd320,
             16'd1,   16'd0,   16'd0,
             16'd1,   16'd0,   16'd0});
`else
      check("corner_win", w1,
            {16'd321, 16'd320, 16'd0,
             16'd1,   16'd0,   16'd0,
             16'd0,   16'd0,   16'd0});
`endif
    end
    if (armed && x == 319 && y == 10) begin
      check("eol_v1", v1, 1);
      check("eol_a1", a1, 3198);
      check("eol_v2", v2, 1);
      check("eol_a2", a2, 3199);
    end
  endtask

  // one strobe then one idle cycle; starts and ends at a negedge
  task automatic pix(input int x, input int y);
    int a;
    bit ev;
    a = y*W + x;
    if (a == 0) armed = 1'b1;
    we_in = 1'b1;
    wAddr_in = 17'(a);
    wData_in = 16'(a);
    @(negedge clk);
    we_in = 1'b0;
    v1 = o_valid;
    a1 = o_wAddr;
    w1 = o_win;
    ev = armed && x >= 1 && y >= 1;
    check("busy_run", o_busy, 0);
    check("valid_1", v1, ev);
    if (ev) begin
      last_addr = (y-1)*W + x - 1;
      check("win_1", w1, exp_win(x-1, y-1));
    end
    check("addr_1", a1, last_addr);
    @(negedge clk);
    v2 = o_valid;
    a2 = o_wAddr;
    w2 = o_win;
    ev = armed && x == W-1 && y >= 1;
    check("valid_2", v2, ev);
    if (ev) begin
      last_addr = (y-1)*W + W - 1;
      check("win_2", w2, exp_win(W-1, y-1));
    end
    check("addr_2", a2, last_addr);
    spot(x, y);
  endtask

  task automatic rows(input int y0, input int x0,
                      input int y1, input int x1);
    for (int a = y0*W + x0; a <= y1*W + x1; a++)
      pix(a % W, a / W);
  endtask

  task automatic flush(input int stop_at);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    while (n < stop_at && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (n > 0) check("flush_consec", o_valid, 1);
      if (o_valid) begin
        check("flush_addr", o_wAddr, (H-1)*W + n);
        check("flush_busy", o_busy, 1);
        check("flush_win", o_win, exp_win(n, H-1));
        if (n == 0) begin
`ifdef WINDOW_BORDER_REPLICATE_EN
          check("flush_bottom", o_win[7*PW +: PW], 3520);
`else
          check("flush_bottom", o_win[7*PW +: PW], 0);
`endif
        end
        last_addr = (H-1)*W + n;
        n++;
      end
    end
    check("flush_count", n, stop_at);
  endtask

  initial begin
    reset = 1'b1;
    we_in = 1'b0;
    wAddr_in = '0;
    wData_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_addr", o_wAddr, 0);
    check("rst_win", o_win, 0);
    check("rst_busy", o_busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // strobes before any frame start are ignored
    pix(5, 3);
    pix(6, 3);

    // frame A with a complete flush
    rows(0, 0, H-1, W-1);
    flush(W);
    check("last_flush_addr", o_wAddr, 3839);
    @(negedge clk);
    check("post_valid", o_valid, 0);
    check("post_busy", o_busy, 0);
    check("post_addr", o_wAddr, 3839);

    // frame B, flush aborted after 100 windows
    rows(0, 0, H-1, W-1);
    flush(100);
    check("abort_addr", o_wAddr, 3619);
    rows(0, 0, 5, 160);

    // reset mid-row
    reset = 1'b1;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_addr", o_wAddr, 0);
    check("mid_rst_win", o_win, 0);
    check("mid_rst_busy", o_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    armed = 1'b0;
    last_addr = 0;
    rows(5, 161, 5, 170);
    rows(0, 0, 2, 20);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
